// File: rtl/conv_complex_seq.sv
// Sequencer for a 3-tap complex convolution that feeds an external multiply-add datapath.
// Optional CONV_OVF_ABORT_EN: a captured datapath overflow aborts the run instead of being flagged only.
//
// state | meaning
// IDLE  | waiting for start; start latches the kernel and clears window/counters
// RUN   | accepting NUM_ELEMS samples into the window
// FLUSH | shifting in two zero samples to finish the tail of the convolution
// FIN   | draining the last result (or reporting an abort) before pulsing done
module conv_complex_seq #(
    parameter int QI          = 3,
    parameter int QF          = 3,
    parameter int NUM_ELEMS   = 100,
    parameter int WORD_LENGTH = QI + QF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [6*WORD_LENGTH-1:0]   kernel,
    input  logic                       s_valid,
    input  logic [WORD_LENGTH-1:0]     s_re,
    input  logic [WORD_LENGTH-1:0]     s_im,
    output logic                       s_ready,
    output logic [6*WORD_LENGTH-1:0]   dp_k,
    output logic [6*WORD_LENGTH-1:0]   dp_x,
    input  logic [WORD_LENGTH-1:0]     dp_re,
    input  logic [WORD_LENGTH-1:0]     dp_im,
    input  logic                       dp_ovf,
    output logic                       m_valid,
    output logic [WORD_LENGTH-1:0]     m_re,
    output logic [WORD_LENGTH-1:0]     m_im,
    input  logic                       m_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow
);

    localparam int WL = WORD_LENGTH;
    localparam int CW = $clog2(NUM_ELEMS + 3);
    localparam logic [CW-1:0] LAST_IN    = CW'(NUM_ELEMS - 1);
    localparam logic [CW-1:0] LAST_FLUSH = CW'(NUM_ELEMS + 1);
    localparam logic [CW-1:0] LAST_OUT   = CW'(NUM_ELEMS + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, FIN} state_t;

    state_t          state;
    logic [CW-1:0]   in_cnt;
    logic [CW-1:0]   out_cnt;
    logic            pend;
`ifdef CONV_OVF_ABORT_EN
    logic            abort_seen;
`endif

    // A step is only taken when the result it produces next cycle is guaranteed a free output register.
    logic step_ok;
    logic accept;
    logic xfer;

    assign step_ok = !pend && (!m_valid || m_ready);
    assign s_ready = (state == RUN) && step_ok;
    assign accept  = s_valid && s_ready;
    assign xfer    = m_valid && m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            in_cnt   <= '0;
            out_cnt  <= '0;
            pend     <= 1'b0;
            dp_k     <= '0;
            dp_x     <= '0;
            m_valid  <= 1'b0;
            m_re     <= '0;
            m_im     <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
`ifdef CONV_OVF_ABORT_EN
            abort_seen <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            pend <= 1'b0;

            if (xfer) begin
                m_valid <= 1'b0;
                out_cnt <= out_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        dp_k     <= kernel;
                        dp_x     <= '0;
                        in_cnt   <= '0;
                        out_cnt  <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
`ifdef CONV_OVF_ABORT_EN
                        abort_seen <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (accept) begin
                        dp_x   <= {dp_x[4*WL-1:0], s_im, s_re};
                        pend   <= 1'b1;
                        in_cnt <= in_cnt + 1'b1;
                        if (in_cnt == LAST_IN) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (step_ok) begin
                        dp_x   <= {dp_x[4*WL-1:0], {2*WL{1'b0}}};
                        pend   <= 1'b1;
                        in_cnt <= in_cnt + 1'b1;
                        if (in_cnt == LAST_FLUSH) state <= FIN;
                    end
                end
                FIN: begin
`ifdef CONV_OVF_ABORT_EN
                    if (abort_seen) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else
`endif
                    if (xfer && out_cnt == LAST_OUT) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Capture never collides with a held result: a step is only taken when the register will be empty.
            if (pend) begin
`ifdef CONV_OVF_ABORT_EN
                if (dp_ovf) begin
                    overflow   <= 1'b1;
                    abort_seen <= 1'b1;
                    state      <= FIN;
                end else begin
                    m_valid <= 1'b1;
                    m_re    <= dp_re;
                    m_im    <= dp_im;
                end
`else
                m_valid <= 1'b1;
                m_re    <= dp_re;
                m_im    <= dp_im;
                if (dp_ovf) overflow <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_conv_complex_seq.sv
// Scoreboard bench for conv_complex_seq with a behavioural model of the external complex MAC datapath.
// Expectations follow CONV_OVF_ABORT_EN the same way the design does.
module tb_conv_complex_seq;

    localparam int QI   = 3;
    localparam int QF   = 3;
    localparam int N    = 4;
    localparam int WL   = QI + QF;
    localparam int NOUT = N + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [6*WL-1:0]   kernel;
    logic              s_valid;
    logic [WL-1:0]     s_re, s_im;
    logic              s_ready;
    logic [6*WL-1:0]   dp_k, dp_x;
    logic [WL-1:0]     dp_re, dp_im;
    logic              dp_ovf;
    logic              m_valid;
    logic [WL-1:0]     m_re, m_im;
    logic              m_ready;
    logic              busy, done, overflow;
    logic              force_ovf;

    always #5 clk = ~clk;

    conv_complex_seq #(.QI(QI), .QF(QF), .NUM_ELEMS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .kernel(kernel),
        .s_valid(s_valid), .s_re(s_re), .s_im(s_im), .s_ready(s_ready),
        .dp_k(dp_k), .dp_x(dp_x), .dp_re(dp_re), .dp_im(dp_im), .dp_ovf(dp_ovf),
        .m_valid(m_valid), .m_re(m_re), .m_im(m_im), .m_ready(m_ready),
        .busy(busy), .done(done), .overflow(overflow)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [6*WL-1:0] mk_k(input int r0, i0, r1, i1, r2, i2);
        return {WL'(i2), WL'(r2), WL'(i1), WL'(r1), WL'(i0), WL'(r0)};
    endfunction

    function automatic logic signed [WL-1:0] fld(input logic [6*WL-1:0] v, input int i);
        return v[i*WL +: WL];
    endfunction

    function automatic bit oor(input longint v);
        return (v > (longint'(1) << (WL-1)) - 1) || (v < -(longint'(1) << (WL-1)));
    endfunction

    // Reference datapath: sum of complex products, rescaled by QF, truncated to WL.
    function automatic logic [2*WL:0] dp_model(input logic [6*WL-1:0] k, input logic [6*WL-1:0] x);
        longint ar = 0, ai = 0, kr, ki, vr, vi;
        for (int j = 0; j < 3; j++) begin
            kr = fld(k, 2*j); ki = fld(k, 2*j+1);
            vr = fld(x, 2*j); vi = fld(x, 2*j+1);
            ar += kr*vr - ki*vi;
            ai += kr*vi + ki*vr;
        end
        ar = ar >>> QF;
        ai = ai >>> QF;
        return {oor(ar) || oor(ai), ai[WL-1:0], ar[WL-1:0]};
    endfunction

    localparam logic [6*WL-1:0] WIN3 = {WL'(0), WL'(1), WL'(0), WL'(2), WL'(0), WL'(3)};

    logic [2*WL:0] dp_res;
    always_comb dp_res = dp_model(dp_k, dp_x);
    assign dp_re  = dp_res[WL-1:0];
    assign dp_im  = dp_res[2*WL-1:WL];
    assign dp_ovf = dp_res[2*WL] | (force_ovf && dp_x == WIN3);

    logic [2*WL-1:0] sb[$];
    logic [2*WL-1:0] sb_head;
    int n_out = 0, n_extra = 0, done_cnt = 0;
    logic ovf_at_done = 1'b0;
    int out0, done0, extra0;
    int xr[N], xi[N];

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            n_out++;
            if (sb.size() == 0) n_extra++;
            else begin
                sb_head = sb.pop_front();
                chk("y_re", m_re, sb_head[WL-1:0]);
                chk("y_im", m_im, sb_head[2*WL-1:WL]);
            end
        end
        if (done) begin
            done_cnt++;
            ovf_at_done = overflow;
            chk("busy_at_done", busy, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input int n_push, output bit eovf);
        longint ar, ai, kr, ki;
        eovf = 1'b0;
        for (int n = 0; n < NOUT; n++) begin
            ar = 0; ai = 0;
            for (int j = 0; j < 3; j++) begin
                if (n - j >= 0 && n - j < N) begin
                    kr = fld(kernel, 2*j); ki = fld(kernel, 2*j+1);
                    ar += kr*xr[n-j] - ki*xi[n-j];
                    ai += kr*xi[n-j] + ki*xr[n-j];
                end
            end
            ar = ar >>> QF;
            ai = ai >>> QF;
            if (oor(ar) || oor(ai)) eovf = 1'b1;
            if (n < n_push) sb.push_back({ai[WL-1:0], ar[WL-1:0]});
        end
    endtask

    task automatic begin_run(input int n_push, output bit eovf);
        push_expected(n_push, eovf);
        out0 = n_out; done0 = done_cnt; extra0 = n_extra;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_run", busy, 1);
    endtask

    task automatic send(input int i, input int gap, input bit lat);
        int t = 0;
        s_valid = 1'b1;
        s_re = WL'(xr[i]);
        s_im = WL'(xi[i]);
        @(negedge clk);
        while (!s_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            chk("accept_timeout", t, 0);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_re = '0; s_im = '0;
        if (lat) begin
            @(negedge clk); chk("lat0", m_valid, 0);
            @(negedge clk); chk("lat1", m_valid, 1);
        end
        repeat (gap) tick();
    endtask

    task automatic end_run(input bit eovf, input int n_exp);
        int t = 0;
        while (done_cnt == done0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk("done_once", done_cnt - done0, 1);
        chk("n_out", n_out - out0, n_exp);
        chk("extra_out", n_extra - extra0, 0);
        chk("sb_left", sb.size(), 0);
        chk("ovf_at_done", ovf_at_done, eovf);
        chk("busy_idle", busy, 0);
        tick();
    endtask

    localparam logic [6*WL-1:0] K1 = {WL'(0), WL'(8), WL'(0), WL'(8), WL'(0), WL'(8)};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit e;
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_re = '0; s_im = '0;
        m_ready = 1'b1; force_ovf = 1'b0; kernel = K1;
        for (int i = 0; i < N; i++) begin xr[i] = i + 1; xi[i] = 0; end
        repeat (2) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_dp_k", dp_k, 0);
        chk("rst_dp_x", dp_x, 0);
        tick();
        rst = 1'b0;

        // Sample offered while idle must be left alone.
        s_valid = 1'b1; s_re = WL'(5);
        repeat (3) begin
            @(negedge clk);
            chk("idle_noacc", s_ready, 0);
        end
        chk("idle_dp_x", dp_x, 0);
        s_valid = 1'b0;
        tick();

        // Basic run: y = 1,3,6,9,7,4.
        begin_run(NOUT, e);
        chk("k_latched", dp_k, K1);
        for (int i = 0; i < N; i++) send(i, 0, 1'b0);
        end_run(e, NOUT);

        // Backpressure after the first result.
        m_ready = 1'b0;
        begin_run(NOUT, e);
        fork
            begin
                for (int i = 0; i < N; i++) send(i, 0, 1'b0);
            end
            begin
                int t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!m_valid && t < 60);
                chk("stall_valid", m_valid, 1);
                for (int k = 0; k < 5; k++) begin
                    chk("stall_re", m_re, 1);
                    chk("stall_rdy", s_ready, 0);
                    if (k < 4) @(negedge clk);
                end
                @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join
        end_run(e, NOUT);

        // Gaps between samples, with 1-cycle latency check on each acceptance.
        begin_run(NOUT, e);
        for (int i = 0; i < N; i++) send(i, 3, 1'b1);
        end_run(e, NOUT);

        // Start pulsed mid-run with a different kernel.
        begin_run(NOUT, e);
        send(0, 0, 1'b0);
        send(1, 0, 1'b0);
        kernel = mk_k(16, 0, 16, 0, 16, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        kernel = K1;
        chk("k_hold", dp_k, K1);
        send(2, 0, 1'b0);
        send(3, 0, 1'b0);
        end_run(e, NOUT);

        // Forced datapath overflow on the third capture.
        force_ovf = 1'b1;
`ifdef CONV_OVF_ABORT_EN
        begin_run(2, e);
        for (int i = 0; i < 3; i++) send(i, 0, 1'b0);
        s_valid = 1'b1; s_re = WL'(4); s_im = '0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_noacc", s_ready, 0);
        end
        s_valid = 1'b0; s_re = '0;
        end_run(1'b1, 2);
`else
        begin_run(NOUT, e);
        for (int i = 0; i < N; i++) send(i, 0, 1'b0);
        end_run(1'b1, NOUT);
`endif
        force_ovf = 1'b0;

        // Reset mid-run, then a clean restart.
        begin_run(NOUT, e);
        send(0, 0, 1'b0);
        send(1, 0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_m_re", m_re, 0);
        chk("mid_rst_m_im", m_im, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_dp_k", dp_k, 0);
        chk("mid_rst_dp_x", dp_x, 0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("mid_rst_no_done", done_cnt - done0, 0);
        while (sb.size() > 0) sb_head = sb.pop_front();
        begin_run(NOUT, e);
        for (int i = 0; i < N; i++) send(i, 0, 1'b0);
        end_run(e, NOUT);

        // Complex-valued taps and samples.
        kernel = mk_k(8, 4, -4, 0, 0, 8);
        xr[0] = 3;  xi[0] = 1;
        xr[1] = -2; xi[1] = 0;
        xr[2] = 5;  xi[2] = -3;
        xr[3] = 1;  xi[3] = 2;
        begin_run(NOUT, e);
        for (int i = 0; i < N; i++) send(i, 1, 1'b0);
        end_run(e, NOUT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
